// File: rtl/blocpu_loader.sv
// blocpu_loader: host-side program loader and run controller for the blocpu core.
//
// Receives a program frame as a byte stream (LEN_HI, LEN_LO, then LEN x {HI, LO}).
// Each {HI[3:0], LO} pair is one 12-bit instruction, written into the core's
// instruction memory at consecutive addresses starting from 0. After the last
// word, the loader resets the core, starts it, and waits for it to halt.
//
// Ports:
//   in_clock / in_reset_n       clock (rising edge), asynchronous active-low reset
//   in_byte, in_byte_valid      host byte stream; out_byte_ready is the matching ready
//   in_abort                    host abort request, level-sampled
//   out_core_instruction/address  data and address for the core's programming port
//   out_core_write/reset/run    registered, mutually exclusive strobes to the core
//   in_core_running             core run flag
//   out_busy, out_done          status: not idle / one-cycle normal halt pulse
//   out_error                   sticky error; cleared by the next frame's first byte
//   out_count                   instructions written in the current or last frame
module blocpu_loader #(
   parameter int CPU_WIDTH         = 8,
   parameter int INSTRUCTION_WIDTH = 12,
   parameter int STROBE_CYCLES     = 2
) (
   input  logic                         in_clock,
   input  logic                         in_reset_n,
   input  logic [7:0]                   in_byte,
   input  logic                         in_byte_valid,
   output logic                         out_byte_ready,
   input  logic                         in_abort,
   output logic [INSTRUCTION_WIDTH-1:0] out_core_instruction,
   output logic [2*CPU_WIDTH-1:0]       out_core_address,
   output logic                         out_core_write,
   output logic                         out_core_reset,
   output logic                         out_core_run,
   input  logic                         in_core_running,
   output logic                         out_busy,
   output logic                         out_done,
   output logic                         out_error,
   output logic [15:0]                  out_count
);

   localparam int              ADDR_WIDTH  = 2 * CPU_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
   localparam logic [4:0]      STROBE_LAST = 5'(STROBE_CYCLES - 1);
   localparam logic [4:0]      STROBE_HIGH = 5'(STROBE_CYCLES);
   localparam logic [4:0]      WRITE_LAST  = 5'(STROBE_CYCLES + 1);

   typedef enum logic [3:0] {
      S_IDLE,
      S_LEN_LO,
      S_WORD_HI,
      S_WORD_LO,
      S_WRITE,
      S_RESET_CORE,
      S_ARM,
      S_START,
      S_RUN,
      S_DONE,
      S_ABORT
   } state_t;

   state_t     state_q, state_d;
   logic [4:0] timer_q, timer_d;       // cycles spent in the current state
   logic [7:0] len_hi_q;
   logic [15:0] len_q;
   logic [3:0] word_hi_q;
   logic       write_d, reset_d, run_d;
   logic       abort_req;
   logic       byte_fire;
   logic       write_exit;

   // Abort is ignored when idle or already aborting, and it blocks a same-cycle byte.
   assign abort_req  = in_abort && (state_q != S_IDLE) && (state_q != S_ABORT);
   assign byte_fire  = in_byte_valid && out_byte_ready && !abort_req;
   assign write_exit = (state_q == S_WRITE) && (timer_q == WRITE_LAST) && !abort_req;

   // ---------------------------------------------------------------- state register
   always_ff @(posedge in_clock or negedge in_reset_n) begin
      if (!in_reset_n) begin
         state_q <= S_IDLE;
         timer_q <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop
         // samples the pre-edge values regardless of statement order.
         state_q <= state_d;
         timer_q <= timer_d;
      end
   end

   // ---------------------------------------------------------------- next state
   always_comb begin
      // NOTE: default first so every path assigns state_d; no latch is inferred.
      state_d = state_q;
      if (abort_req) begin
         state_d = S_ABORT;
      end else begin
         unique case (state_q)
            S_IDLE:       if (byte_fire) state_d = S_LEN_LO;
            S_LEN_LO:     if (byte_fire)
                             state_d = ({len_hi_q, in_byte} == 16'd0) ? S_RESET_CORE : S_WORD_HI;
            S_WORD_HI:    if (byte_fire)
                             state_d = (in_byte[7:4] != 4'd0) ? S_IDLE : S_WORD_LO;
            S_WORD_LO:    if (byte_fire) state_d = S_WRITE;
            S_WRITE:      if (timer_q == WRITE_LAST)
                             state_d = ((out_count + 16'd1) == len_q) ? S_RESET_CORE : S_WORD_HI;
            S_RESET_CORE: if (timer_q == STROBE_LAST) state_d = S_ARM;
            S_ARM:        state_d = S_START;
            S_START:      if (timer_q == STROBE_LAST) state_d = S_RUN;
            S_RUN:        if (!in_core_running) state_d = S_DONE;
            S_DONE:       state_d = S_IDLE;
            S_ABORT:      if (timer_q == STROBE_LAST) state_d = S_IDLE;
            default:      state_d = S_IDLE;
         endcase
      end
      timer_d = (state_d != state_q) ? 5'd0 : timer_q + 5'd1;
   end

   // ---------------------------------------------------------------- outputs
   // Strobe values are computed from the upcoming state/timer and registered, so
   // each strobe is a clean flop output that lines up exactly with its state.
   always_comb begin
      out_byte_ready = (state_q == S_IDLE) || (state_q == S_LEN_LO) ||
                       (state_q == S_WORD_HI) || (state_q == S_WORD_LO);
      out_busy       = (state_q != S_IDLE);
      out_done       = (state_q == S_DONE);
      // Write is high on WRITE cycles 1..STROBE_CYCLES: one setup and one hold cycle.
      write_d        = (state_d == S_WRITE) && (timer_d != 5'd0) && (timer_d <= STROBE_HIGH);
      reset_d        = (state_d == S_RESET_CORE) || (state_d == S_ABORT);
      run_d          = (state_d == S_START);
   end

   always_ff @(posedge in_clock or negedge in_reset_n) begin
      if (!in_reset_n) begin
         out_core_write <= 1'b0;
         out_core_reset <= 1'b0;
         out_core_run   <= 1'b0;
      end else begin
         out_core_write <= write_d;
         out_core_reset <= reset_d;
         out_core_run   <= run_d;
      end
   end

   // ---------------------------------------------------------------- datapath
   always_ff @(posedge in_clock or negedge in_reset_n) begin
      if (!in_reset_n) begin
         len_hi_q             <= '0;
         len_q                <= '0;
         word_hi_q            <= '0;
         out_core_instruction <= '0;
         out_core_address     <= '0;
         out_count            <= '0;
         out_error            <= 1'b0;
      end else begin
         if (byte_fire) begin
            unique case (state_q)
               S_IDLE: begin
                  len_hi_q         <= in_byte;
                  out_error        <= 1'b0;
                  out_count        <= '0;
                  out_core_address <= '0;
               end
               S_LEN_LO:  len_q <= {len_hi_q, in_byte};
               S_WORD_HI: begin
                  word_hi_q <= in_byte[3:0];
                  if (in_byte[7:4] != 4'd0) out_error <= 1'b1;
               end
               S_WORD_LO: out_core_instruction <= INSTRUCTION_WIDTH'({word_hi_q, in_byte});
               default: ;
            endcase
         end
         if (write_exit) begin
            out_core_address <= out_core_address + ADDR_ONE;
            out_count        <= out_count + 16'd1;
         end
         if ((state_q == S_ABORT) && (state_d == S_IDLE)) out_error <= 1'b1;
      end
   end

endmodule

// File: tb/tb_blocpu_loader.sv
// Directed testbench for blocpu_loader (default parameters, STROBE_CYCLES=2).
// A negedge monitor records strobe edges, pulse widths, write address/data and
// data stability; the main sequence compares those records with hand-computed values.
module tb_blocpu_loader;

   logic        clock;
   logic        in_reset_n;
   logic [7:0]  in_byte;
   logic        in_byte_valid;
   logic        out_byte_ready;
   logic        in_abort;
   logic [11:0] out_core_instruction;
   logic [15:0] out_core_address;
   logic        out_core_write;
   logic        out_core_reset;
   logic        out_core_run;
   logic        in_core_running;
   logic        out_busy;
   logic        out_done;
   logic        out_error;
   logic [15:0] out_count;

   blocpu_loader dut (
      .in_clock             (clock),
      .in_reset_n           (in_reset_n),
      .in_byte              (in_byte),
      .in_byte_valid        (in_byte_valid),
      .out_byte_ready       (out_byte_ready),
      .in_abort             (in_abort),
      .out_core_instruction (out_core_instruction),
      .out_core_address     (out_core_address),
      .out_core_write       (out_core_write),
      .out_core_reset       (out_core_reset),
      .out_core_run         (out_core_run),
      .in_core_running      (in_core_running),
      .out_busy             (out_busy),
      .out_done             (out_done),
      .out_error            (out_error),
      .out_count            (out_count)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   int cyc = 0;
   initial forever begin
      @(posedge clock);
      cyc = cyc + 1;
   end

   // ---------------------------------------------------------------- monitor
   int          wr_rises = 0, rst_rises = 0, run_rises = 0, done_cnt = 0;
   int          wr_unstable = 0, overlaps = 0;
   int          wr_cur = 0, rst_cur = 0, run_cur = 0;
   int          last_rst_width = 0, last_run_width = 0;
   int          rst_fall_cyc = 0, run_rise_cyc = 0, done_cyc = 0;
   int          wr_width [16];
   logic [15:0] wr_addr  [16];
   logic [11:0] wr_data  [16];
   logic        p_wr = 1'b0, p_rst = 1'b0, p_run = 1'b0;
   logic [15:0] p_addr = '0;
   logic [11:0] p_instr = '0;

   initial forever begin
      @(negedge clock);
      if (int'(out_core_write) + int'(out_core_reset) + int'(out_core_run) > 1) overlaps++;
      if (out_core_write && !p_wr) begin
         wr_addr[wr_rises % 16] = out_core_address;
         wr_data[wr_rises % 16] = out_core_instruction;
         if (out_core_address != p_addr || out_core_instruction != p_instr) wr_unstable++;
         wr_rises++;
         wr_cur = 1;
      end else if (out_core_write && p_wr) begin
         wr_cur++;
         if (out_core_address != p_addr || out_core_instruction != p_instr) wr_unstable++;
      end else if (!out_core_write && p_wr) begin
         wr_width[(wr_rises - 1) % 16] = wr_cur;
         if (out_core_address != p_addr || out_core_instruction != p_instr) wr_unstable++;
      end
      if (out_core_reset && !p_rst) begin rst_rises++; rst_cur = 1; end
      else if (out_core_reset) rst_cur++;
      else if (p_rst) begin last_rst_width = rst_cur; rst_fall_cyc = cyc; end
      if (out_core_run && !p_run) begin run_rises++; run_cur = 1; run_rise_cyc = cyc; end
      else if (out_core_run) run_cur++;
      else if (p_run) last_run_width = run_cur;
      if (out_done) begin done_cnt++; done_cyc = cyc; end
      p_wr    = out_core_write;
      p_rst   = out_core_reset;
      p_run   = out_core_run;
      p_addr  = out_core_address;
      p_instr = out_core_instruction;
   end

   // ---------------------------------------------------------------- checking
   int n_checks = 0;
   int n_pass   = 0;
   int accept_cyc = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(negedge clock);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int t = 0;
      @(negedge clock);
      in_byte       = b;
      in_byte_valid = 1'b1;
      while (!out_byte_ready && t < 50) begin
         @(negedge clock);
         t++;
      end
      if (t >= 50) check("byte_ready_timeout", 32'(out_byte_ready), 32'd1);
      @(posedge clock);
      #1;
      accept_cyc    = cyc;
      in_byte_valid = 1'b0;
   endtask

   task automatic wait_done(input int base, input int budget);
      int t = 0;
      while (done_cnt == base && t < budget) begin
         tick();
         t++;
      end
      check("done_seen", 32'(done_cnt - base), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------- stimulus
   initial begin
      int wb, rb, nb, db, acc, t;
      in_reset_n      = 1'b0;
      in_byte         = 8'h00;
      in_byte_valid   = 1'b0;
      in_abort        = 1'b0;
      in_core_running = 1'b0;

      // Reset state
      repeat (3) tick();
      check("rst_ready", 32'(out_byte_ready), 32'd1);
      check("rst_busy",  32'(out_busy), 32'd0);
      check("rst_strobes", {29'd0, out_core_write, out_core_reset, out_core_run}, 32'd0);
      check("rst_addr",  32'(out_core_address), 32'd0);
      check("rst_instr", 32'(out_core_instruction), 32'd0);
      check("rst_count", 32'(out_count), 32'd0);
      check("rst_flags", {30'd0, out_done, out_error}, 32'd0);
      in_reset_n = 1'b1;
      repeat (3) tick();
      check("post_rst_ready", 32'(out_byte_ready), 32'd1);
      check("post_rst_edges", 32'(wr_rises + rst_rises + run_rises), 32'd0);

      // Frame 00 02 08 05 0A 07
      wb = wr_rises; rb = rst_rises; nb = run_rises; db = done_cnt; t = wr_unstable;
      send_byte(8'h00); send_byte(8'h02);
      send_byte(8'h08); send_byte(8'h05);
      send_byte(8'h0A); send_byte(8'h07);
      wait_done(db, 60);
      check("f1_writes",   32'(wr_rises - wb), 32'd2);
      check("f1_addr0",    32'(wr_addr[wb % 16]), 32'h0000);
      check("f1_data0",    32'(wr_data[wb % 16]), 32'h805);
      check("f1_width0",   32'(wr_width[wb % 16]), 32'd2);
      check("f1_addr1",    32'(wr_addr[(wb + 1) % 16]), 32'h0001);
      check("f1_data1",    32'(wr_data[(wb + 1) % 16]), 32'hA07);
      check("f1_width1",   32'(wr_width[(wb + 1) % 16]), 32'd2);
      check("f1_stable",   32'(wr_unstable - t), 32'd0);
      check("f1_resets",   32'(rst_rises - rb), 32'd1);
      check("f1_rst_width", 32'(last_rst_width), 32'd2);
      check("f1_runs",     32'(run_rises - nb), 32'd1);
      check("f1_run_width", 32'(last_run_width), 32'd2);
      check("f1_arm_gap",  32'(run_rise_cyc - rst_fall_cyc), 32'd1);
      check("f1_count",    32'(out_count), 32'd2);
      check("f1_error",    32'(out_error), 32'd0);
      check("f1_overlap",  32'(overlaps), 32'd0);

      // Frame 00 00: no writes, done 6 cycles after LEN_LO
      wb = wr_rises; rb = rst_rises; nb = run_rises; db = done_cnt;
      send_byte(8'h00); send_byte(8'h00);
      acc = accept_cyc;
      wait_done(db, 30);
      check("f0_done_latency", 32'(done_cyc - acc), 32'd6);
      check("f0_writes", 32'(wr_rises - wb), 32'd0);
      check("f0_resets", 32'(rst_rises - rb), 32'd1);
      check("f0_runs",   32'(run_rises - nb), 32'd1);
      check("f0_count",  32'(out_count), 32'd0);

      // Frame 00 01 18 ..: bad HI nibble
      tick();
      wb = wr_rises; rb = rst_rises; nb = run_rises;
      send_byte(8'h00); send_byte(8'h01); send_byte(8'h18);
      tick();
      check("err_flag",   32'(out_error), 32'd1);
      check("err_busy",   32'(out_busy), 32'd0);
      check("err_ready",  32'(out_byte_ready), 32'd1);
      check("err_strobes", 32'(wr_rises - wb + rst_rises - rb + run_rises - nb), 32'd0);
      send_byte(8'h00);
      tick();
      check("err_cleared", 32'(out_error), 32'd0);
      check("err_new_busy", 32'(out_busy), 32'd1);

      // Complete as N=0 with the core running, then abort in RUN
      in_core_running = 1'b1;
      nb = run_rises; db = done_cnt;
      send_byte(8'h00);
      t = 0;
      while (!(run_rises > nb && !out_core_run) && t < 40) begin tick(); t++; end
      check("ab_run_pulse", 32'(run_rises - nb), 32'd1);
      tick(); tick();
      check("ab_in_run", 32'(out_busy), 32'd1);
      rb = rst_rises;
      @(negedge clock);
      in_abort = 1'b1;
      @(posedge clock);
      #1;
      in_abort = 1'b0;
      t = 0;
      while (out_busy && t < 20) begin tick(); t++; end
      check("ab_idle",      32'(out_busy), 32'd0);
      check("ab_resets",    32'(rst_rises - rb), 32'd1);
      check("ab_rst_width", 32'(last_rst_width), 32'd2);
      check("ab_error",     32'(out_error), 32'd1);
      in_core_running = 1'b0;
      tick(); tick();
      check("ab_no_done",   32'(done_cnt - db), 32'd0);

      // Reset mid-WRITE, then a fresh frame restarts at address 0
      wb = wr_rises;
      send_byte(8'h00); send_byte(8'h03);
      send_byte(8'h01); send_byte(8'h11);
      send_byte(8'h02); send_byte(8'h22);
      t = 0;
      while (!(wr_rises - wb >= 2 && out_core_write) && t < 40) begin tick(); t++; end
      check("mr_write_high", 32'(out_core_write), 32'd1);
      check("mr_addr_before", 32'(out_core_address), 32'h0001);
      check("mr_data_before", 32'(out_core_instruction), 32'h222);
      #2;
      in_reset_n = 1'b0;
      #1;
      check("mr_write_drop", 32'(out_core_write), 32'd0);
      check("mr_addr_reset", 32'(out_core_address), 32'd0);
      check("mr_count_reset", 32'(out_count), 32'd0);
      check("mr_busy",       32'(out_busy), 32'd0);
      tick();
      in_reset_n = 1'b1;
      tick();
      wb = wr_rises; db = done_cnt;
      send_byte(8'h00); send_byte(8'h01);
      send_byte(8'h04); send_byte(8'h56);
      wait_done(db, 40);
      check("mr_writes", 32'(wr_rises - wb), 32'd1);
      check("mr_addr",   32'(wr_addr[wb % 16]), 32'h0000);
      check("mr_data",   32'(wr_data[wb % 16]), 32'h456);
      check("mr_count",  32'(out_count), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/blocpu_loader.md
# blocpu_loader

Host-side program loader and run controller for the blocpu core. Accepts a byte-stream program frame over a valid/ready channel and assembles 12-bit instructions. Writes them into the core's instruction memory through its address/data/write-strobe programming port, then resets and starts the core. Supervises the run until the core halts, and reports busy/done/error status to the host.

## Interface
- CPU_WIDTH, 8: core word width; core address width is 2*CPU_WIDTH.
- INSTRUCTION_WIDTH, 12: core instruction width. The frame format below is fixed for 12.
- STROBE_CYCLES, 2: high time of every pulse driven to the core (write, reset, run), in cycles; legal range 1–15.

Ports:
- in_clock  in  1  sole clock; all logic on rising edge.
- in_reset_n  in  1  asynchronous, active-low reset.
- in_byte  in  8  host byte.
- in_byte_valid  in  1  host byte valid.
- out_byte_ready  out  1  loader can accept a byte; transfer on a rising edge with valid & ready.
- in_abort  in  1  host abort request, level-sampled.
- out_core_instruction  out  INSTRUCTION_WIDTH  to core in_instruction.
- out_core_address  out  2*CPU_WIDTH  to core in_instruction_address.
- out_core_write  out  1  to core in_instruction_write; the core captures on its rising edge.
- out_core_reset  out  1  to core in_reset, pulse.
- out_core_run  out  1  to core in_running, pulse.
- in_core_running  in  1  from core out_running.
- out_busy  out  1  high in every state except IDLE.
- out_done  out  1  one-cycle pulse when the program halts normally.
- out_error  out  1  sticky error flag; cleared when the next frame's first byte is accepted.
- out_count  out  16  number of instructions written in the current or last frame.

## Operation
- Frame format: LEN_HI, LEN_LO (N, 16-bit big-endian), then N × {HI, LO}.
  - instruction = {HI[3:0], LO}.
  - HI[7:4] must be 0.
  - N=0 loads nothing but still resets and starts the core.
- States: IDLE → LEN_LO → (WORD_HI → WORD_LO → WRITE)×N → RESET_CORE → ARM → START → RUN → DONE → IDLE; ABORT from any non-IDLE state.
- out_byte_ready is 1 exactly in IDLE, LEN_LO, WORD_HI and WORD_LO; it is 0 in all other states.
- IDLE: an accepted byte is captured as LEN_HI and clears out_error and out_count.
- LEN_LO: captures LEN_LO. If N=0, go to RESET_CORE; otherwise go to WORD_HI.
- WORD_HI: if HI[7:4] ≠ 0, set out_error and return to IDLE. The rest of the frame is not consumed, so following bytes start a new frame. The core is not touched.
- WRITE: lasts STROBE_CYCLES+2 cycles.
  - Cycle 0: address and instruction become valid, write low (setup).
  - Cycles 1..STROBE_CYCLES: write high.
  - Last cycle: write low (hold).
  - On exit: address and out_count increment. If out_count equals N, go to RESET_CORE; otherwise go to WORD_HI.
- Addresses start at 0 per frame and are ≤ 0xFFFE, so the address never wraps.
- RESET_CORE: out_core_reset high for STROBE_CYCLES cycles.
- ARM: 1 cycle with all strobes low.
- START: out_core_run high for STROBE_CYCLES cycles.
- RUN: stays while in_core_running=1 and goes to DONE on the first cycle it samples 0. A program that halts before RUN is entered ends immediately.
- DONE: 1 cycle with out_done=1, then IDLE.
- in_abort=1 in any state except IDLE/ABORT: go to ABORT.
  - ABORT pulses out_core_reset for STROBE_CYCLES cycles, which clears the core's running flag.
  - Then out_error is set and the state returns to IDLE. No out_done pulse.
  - Abort has priority over a same-cycle byte transfer, which is not accepted.
- Strobes are registered, glitch-free, and mutually exclusive.
- out_core_address and out_core_instruction hold their last value outside WRITE.

## Timing
- Reset (in_reset_n=0), asynchronous:
  - State IDLE.
  - All strobes 0.
  - out_core_address 0, out_core_instruction 0, out_count 0.
  - out_busy 0, out_done 0, out_error 0.
  - out_byte_ready 1 (IDLE). Bytes are not accepted while reset is asserted.
- Reset asserted mid-WRITE or mid-pulse drops the strobe immediately. Any partially written program is abandoned.
- Per instruction, with valid held high: 2 cycles (HI, LO) + STROBE_CYCLES+2.
- Frame-end to core start: RESET_CORE (STROBE_CYCLES) + ARM (1) + START (STROBE_CYCLES) cycles.
- DONE is asserted 1 cycle after RUN samples in_core_running=0.

## Test plan
- Reset release: all outputs at the reset values above; out_byte_ready=1; no strobe edges.
- Frame 00 02 08 05 0A 07, STROBE_CYCLES=2:
  - Writes 0x805@0x0000 and 0xA07@0x0001, each with write high for 2 cycles and data stable 1 cycle before and after.
  - Then a 2-cycle reset pulse, 1 idle cycle, and a 2-cycle run pulse.
  - out_count=2.
- Frame 00 00: no write strobes; reset and run pulses are issued; with in_core_running held low, out_done pulses 6 cycles after LEN_LO is accepted.
- Frame 00 01 18 00: out_error=1, no strobes, back to IDLE; the next byte clears out_error.
- in_abort raised in RUN with in_core_running=1: 2-cycle reset pulse, out_error=1, IDLE, no out_done.
- in_reset_n dropped mid-WRITE: out_core_write falls immediately; after release, a new frame loads starting at address 0.
